// File: rtl/core_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_run_pkg
// Shared definitions for the core run controller:
//   - run_state_t : controller FSM encoding (3 bits)
//   - OPC_ECALL / OPC_EBREAK : the two encodings that end a run
//   - is_halt_opc() : matches either halting encoding
// -----------------------------------------------------------------------------
package core_run_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESET   = 3'd1,
        RUN     = 3'd2,
        HALT    = 3'd3,
        TIMEOUT = 3'd4
    } run_state_t;

    localparam logic [31:0] OPC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] OPC_EBREAK = 32'h0010_0073;

    // Exact 32-bit match: these are full-word system encodings, so any
    // other funct12/rs1/rd value (e.g. 0x00200073) must not stop the run.
    function automatic logic is_halt_opc(input logic [31:0] op);
        return (op == OPC_ECALL) || (op == OPC_EBREAK);
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// -----------------------------------------------------------------------------
// run_cycle_counter
// Saturating up-counter with synchronous clear, count enable and a
// terminal-value compare. Used both for the core reset hold time and for
// the run-cycle budget.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active low (count -> 0)
//   clr   in   synchronous clear (wins over en)
//   en    in   count enable; holds at all-ones once reached
//   cnt   out  current count (registered)
//   term  out  high while cnt == TERM
// -----------------------------------------------------------------------------
module run_cycle_counter #(
    parameter int              W    = 32,
    parameter longint unsigned TERM = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         term
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign term = (cnt == TERM_V);

endmodule

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
// Run controller for the single-cycle core: holds the core in reset for
// RST_HOLD cycles after start, lets it run, and stops it on ECALL/EBREAK
// or when the run-cycle budget (MAX_CYCLES, 0 = unlimited) is used up.
// Repeated runs are started with start; abort returns to IDLE at any time.
//
// Optional build macro CORE_RUN_SIG_EN adds a rotate-xor PC trace
// signature output (sig) for comparing executions against golden values.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   start        in   begin a run (honoured in IDLE/HALT/TIMEOUT only)
//   abort        in   force IDLE next cycle (beats start)
//   instr_valid  in   instr/pc valid this cycle
//   instr        in   instruction executing in the core
//   pc           in   PC of instr
//   core_rst     out  active-high reset to the core
//   core_en      out  core clock enable
//   busy         out  high in RESET or RUN
//   done         out  high in HALT or TIMEOUT
//   timed_out    out  high in TIMEOUT
//   cycle_cnt    out  RUN cycles elapsed (saturating, frozen after stop)
//   halt_pc      out  PC of the halting instruction
//   sig          out  PC trace signature (CORE_RUN_SIG_EN only)
// -----------------------------------------------------------------------------
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int unsigned RST_HOLD   = 3,
    parameter int unsigned MAX_CYCLES = 1024,
    parameter int          CNT_W      = 32,
    parameter int          PC_W       = 32,
    parameter int          INSTR_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc,
    output logic               core_rst,
    output logic               core_en,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [PC_W-1:0]    halt_pc
`ifdef CORE_RUN_SIG_EN
    ,
    output logic [PC_W-1:0]    sig
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (INSTR_W < 32) begin : g_bad_instr_w
            $error("core_run_ctrl: INSTR_W must be at least 32");
        end
        if (RST_HOLD < 1) begin : g_bad_rst_hold
            $error("core_run_ctrl: RST_HOLD must be at least 1");
        end
    endgenerate

    // Hold counter counts 0 .. RST_HOLD-1 while in RESET; the width covers
    // RST_HOLD so RST_HOLD=1 still gets a 1-bit counter.
    localparam int              HOLD_W   = $clog2(RST_HOLD + 1);
    localparam longint unsigned HOLD_END = longint'(RST_HOLD) - 1;
    localparam logic            TO_EN    = (MAX_CYCLES != 0);
    localparam longint unsigned RUN_END  = TO_EN ? (longint'(MAX_CYCLES) - 1) : 0;

    run_state_t  state, next;
    logic        go;
    logic        halt_hit;
    logic        hold_done;
    logic        run_limit;
    logic        run_stay;
    logic [HOLD_W-1:0] hold_cnt;

    // next-cycle values of the registered status outputs
    logic        nxt_core_rst, nxt_core_en, nxt_busy, nxt_done, nxt_timed_out;

    // A start only counts outside RESET/RUN and only when abort is quiet.
    assign go       = start && !abort &&
                      ((state == IDLE) || (state == HALT) || (state == TIMEOUT));
    assign halt_hit = instr_valid && is_halt_opc(instr[31:0]);
    assign run_stay = (state == RUN) && (next == RUN);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    run_cycle_counter #(
        .W    (HOLD_W),
        .TERM (HOLD_END)
    ) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (state == RESET),
        .cnt  (hold_cnt),
        .term (hold_done)
    );

    // Only cycles that stay in RUN advance the count, so the value seen
    // alongside the halting/terminal cycle is the one left frozen.
    run_cycle_counter #(
        .W    (CNT_W),
        .TERM (RUN_END)
    ) u_run_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (run_stay),
        .cnt  (cycle_cnt),
        .term (run_limit)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (go) next = RESET;
            RESET:   if (hold_done) next = RUN;
            RUN: begin
                // halt beats timeout when both land on the same cycle
                if (halt_hit)                next = HALT;
                else if (TO_EN && run_limit) next = TIMEOUT;
            end
            HALT,
            TIMEOUT: if (go) next = RESET;
            default: next = IDLE;
        endcase
        if (abort) next = IDLE;

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state itself.
        nxt_core_rst  = (next == IDLE) || (next == RESET);
        nxt_core_en   = (next == RUN);
        nxt_busy      = (next == RESET) || (next == RUN);
        nxt_done      = (next == HALT) || (next == TIMEOUT);
        nxt_timed_out = (next == TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            core_rst  <= nxt_core_rst;
            core_en   <= nxt_core_en;
            busy      <= nxt_busy;
            done      <= nxt_done;
            timed_out <= nxt_timed_out;
        end
    end

    // ------------------------------------------------------------------
    // Halt PC capture: cleared by a new run, kept across abort
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_pc <= '0;
        end else if (go) begin
            halt_pc <= '0;
        end else if ((state == RUN) && (next == HALT)) begin
            halt_pc <= pc;
        end
    end

`ifdef CORE_RUN_SIG_EN
    // ------------------------------------------------------------------
    // PC trace signature: rotate left by one, xor in the retired PC.
    // Only RUN cycles contribute, so it freezes along with cycle_cnt.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig <= '0;
        end else if (go) begin
            sig <= '0;
        end else if ((state == RUN) && instr_valid) begin
            sig <= {sig[PC_W-2:0], sig[PC_W-1]} ^ pc;
        end
    end
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_run_ctrl
// Directed bench for core_run_ctrl (RST_HOLD=3, MAX_CYCLES=20). The
// stimulus thread drives inputs on falling edges and queues the expected
// outputs for specific future cycles; a monitor thread pops each entry
// when its cycle comes up and compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_core_run_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, instr_valid;
    logic [31:0] instr, pc;
    logic        core_rst, core_en, busy, done, timed_out;
    logic [31:0] cycle_cnt, halt_pc;
`ifdef CORE_RUN_SIG_EN
    logic [31:0] sig;
`endif

    core_run_ctrl #(
        .RST_HOLD   (3),
        .MAX_CYCLES (20),
        .CNT_W      (32),
        .PC_W       (32),
        .INSTR_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .core_rst    (core_rst),
        .core_en     (core_en),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_cnt   (cycle_cnt),
        .halt_pc     (halt_pc)
`ifdef CORE_RUN_SIG_EN
        ,
        .sig         (sig)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ctl = {core_rst, core_en, busy, done, timed_out}
    typedef struct {
        int          at;
        string       nm;
        logic [4:0]  ctl;
        logic [31:0] cnt;
        logic [31:0] hpc;
        bit          sig_chk;
        logic [31:0] sig;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    event probe;

    task automatic push(input int at, input string nm, input logic [4:0] ctl,
                        input logic [31:0] cnt, input logic [31:0] hpc);
        exp_t e;
        e.at = at; e.nm = nm; e.ctl = ctl; e.cnt = cnt; e.hpc = hpc;
        e.sig_chk = 1'b0; e.sig = '0;
        q.push_back(e);
    endtask

    task automatic push_sig(input int at, input string nm, input logic [4:0] ctl,
                            input logic [31:0] cnt, input logic [31:0] s);
        exp_t e;
        e.at = at; e.nm = nm; e.ctl = ctl; e.cnt = cnt; e.hpc = '0;
        e.sig_chk = 1'b1; e.sig = s;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // status patterns {core_rst, core_en, busy, done, timed_out}
    localparam logic [4:0] C_IDLE = 5'b10000;
    localparam logic [4:0] C_RST  = 5'b10100;
    localparam logic [4:0] C_RUN  = 5'b01100;
    localparam logic [4:0] C_HALT = 5'b00010;
    localparam logic [4:0] C_TO   = 5'b00011;

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk or probe);
            while (q.size() > 0 && q[0].at <= cyc) begin
                exp_t e;
                logic [4:0] act;
                logic ok;
                e   = q.pop_front();
                act = {core_rst, core_en, busy, done, timed_out};
                checks++;
                if (e.at < cyc) begin
                    errors++;
                    $display("FAIL %s missed: due cyc=%0d now cyc=%0d", e.nm, e.at, cyc);
                end else begin
                    ok = (act === e.ctl) && (cycle_cnt === e.cnt) && (halt_pc === e.hpc);
`ifdef CORE_RUN_SIG_EN
                    if (e.sig_chk && (sig !== e.sig)) ok = 1'b0;
                    if (e.sig_chk && !ok)
                        $display("  %s sig got=%h want=%h", e.nm, sig, e.sig);
`endif
                    if (!ok) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got ctl=%b cnt=%0d hpc=%h want ctl=%b cnt=%0d hpc=%h",
                                 e.nm, cyc, act, cycle_cnt, halt_pc, e.ctl, e.cnt, e.hpc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        instr_valid = 1'b0; instr = NOP; pc = '0;
        push(1, "reset_vals", C_IDLE, 0, 0);

        wait_cyc(2);
        rst = 1'b1;
        push(3, "idle_a", C_IDLE, 0, 0);
        push(5, "idle_b", C_IDLE, 0, 0);

        // run 1: start at cycle 5, RESET 6..8, RUN from 9
        wait_cyc(5);
        start = 1'b1;
        push(6, "hold_first", C_RST, 0, 0);
        push(8, "hold_last",  C_RST, 0, 0);
        push(9, "run_first",  C_RUN, 0, 0);
        push_sig(10, "sig_pc0", C_RUN, 1, 32'h0000_0000);
        push_sig(11, "sig_pc4", C_RUN, 2, 32'h0000_0004);
        push_sig(12, "sig_pc8", C_RUN, 3, 32'h0000_0000);
        wait_cyc(6);  start = 1'b0;
        wait_cyc(9);  instr_valid = 1'b1; pc = 32'h0;
        wait_cyc(10); pc = 32'h4;
        wait_cyc(11); pc = 32'h8;
        wait_cyc(12); instr_valid = 1'b0;

        wait_cyc(20);  // ECALL without instr_valid must not halt
        instr = ECALL; pc = 32'h20;
        push(21, "ecall_novalid", C_RUN, 12, 0);
        wait_cyc(21);  // near-miss encoding must not halt
        instr = 32'h0020_0073; instr_valid = 1'b1;
        push(22, "near_miss", C_RUN, 13, 0);
        wait_cyc(22);
        instr = NOP;
        push(26, "run17", C_RUN, 17, 0);

        wait_cyc(26);
        instr = ECALL; pc = 32'h40;
        push(27, "ecall_halt", C_HALT, 17, 32'h40);
        push(30, "halt_frozen", C_HALT, 17, 32'h40);
        wait_cyc(27);
        instr = NOP; pc = 32'h44;

        // run 2: restart from HALT, runs into the budget
        wait_cyc(31);
        start = 1'b1;
        push(32, "rerun_hold", C_RST, 0, 0);
        push(35, "rerun_run0", C_RUN, 0, 0);
        push(54, "rerun_cnt19", C_RUN, 19, 0);
        push(55, "timeout", C_TO, 19, 0);
        push(57, "timeout_frozen", C_TO, 19, 0);
        wait_cyc(32); start = 1'b0;

        // run 3: restart from TIMEOUT, EBREAK on the terminal cycle
        wait_cyc(58);
        start = 1'b1;
        push(59, "from_to_hold", C_RST, 0, 0);
        push(62, "from_to_run0", C_RUN, 0, 0);
        push(81, "limit_cycle", C_RUN, 19, 0);
        wait_cyc(59); start = 1'b0;
        wait_cyc(81);
        instr = EBREAK; pc = 32'h80;
        push(82, "ebreak_wins", C_HALT, 19, 32'h80);
        wait_cyc(82);
        instr = NOP;

        // run 4: abort (with start) mid-RUN
        wait_cyc(84);
        start = 1'b1;
        push(88, "run4_first", C_RUN, 0, 0);
        push(98, "run4_cnt10", C_RUN, 10, 0);
        push(99, "abort_idle", C_IDLE, 10, 0);
        push(100, "abort_kept", C_IDLE, 10, 0);
        wait_cyc(85); start = 1'b0;
        wait_cyc(98); abort = 1'b1; start = 1'b1;
        wait_cyc(99); abort = 1'b0; start = 1'b0;

        // run 5: fresh run after abort; start while busy is ignored
        wait_cyc(101);
        start = 1'b1;
        push(102, "fresh_clear", C_RST, 0, 0);
        push(105, "fresh_run0", C_RUN, 0, 0);
        push(111, "busy_start_ign", C_RUN, 6, 0);
        wait_cyc(102); start = 1'b0;
        wait_cyc(110); start = 1'b1;
        wait_cyc(111); start = 1'b0;

        // asynchronous reset mid-RUN, observed before the next clock edge
        wait_cyc(115);
        #3;
        rst = 1'b0;
        push(115, "async_rst", C_IDLE, 0, 0);
        push(116, "rst_held", C_IDLE, 0, 0);
        #1;
        -> probe;
        wait_cyc(117);
        rst = 1'b1;
        push(118, "idle_after_rst", C_IDLE, 0, 0);

        wait_cyc(120);
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL pending: %0d expectations never checked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
